alu_seq: RTL and testbench

// - Parametrised multi-cycle ALU for the datapath; replaces the combinational ALU.
// - Adds registered results, a start/busy/done handshake and shift/rotate by a variable amount.
// - Adds iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes).
// - Sits between the A/B operand registers and the Z (HI/LO) result registers; the control unit waits on done.

---
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with start/busy/done handshake.
// Single-cycle ops complete in one cycle. MUL is a radix-2 Booth multiplier.
// DIV is a restoring divider that works on magnitudes and fixes signs afterwards.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_SHRA = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_ROR  = 4'b1001;
    localparam logic [3:0] OP_ROL  = 4'b1010;
    localparam logic [3:0] OP_NEG  = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t           state, state_n;
    logic [SHW-1:0]   cnt;
    logic             last;

    logic [SHW-1:0]   sh, nsh;
    logic [WIDTH-1:0] single;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Booth multiplier: acc_hi has one guard bit so MIN*MIN cannot overflow
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             qm1;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   booth_sum, hi_n;
    logic [WIDTH-1:0] lo_n;

    // Restoring divider on magnitudes
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_n, quo_n;

    assign last  = (cnt == '1);
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Single-cycle results; rotate-left is a rotate-right by the negated amount
    always_comb begin
        sh     = b[SHW-1:0];
        nsh    = -sh;
        single = '0;
        case (op)
            OP_ADD:  single = a + b;
            OP_SUB:  single = a - b;
            OP_AND:  single = a & b;
            OP_OR:   single = a | b;
            OP_SHR:  single = a >> sh;
            OP_SHRA: single = $signed(a) >>> sh;
            OP_SHL:  single = a << sh;
            OP_ROR:  single = WIDTH'({a, a} >> sh);
            OP_ROL:  single = WIDTH'({a, a} >> nsh);
            OP_NEG:  single = -a;
            OP_NOT:  single = ~a;
            default: single = '0;
        endcase
    end

    // One Booth step: add/subtract the sign-extended multiplicand, then arithmetic shift right
    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], qm1})
            2'b01:   booth_sum = acc_hi + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = acc_hi - {mcand[WIDTH-1], mcand};
            default: booth_sum = acc_hi;
        endcase
        hi_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        lo_n = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_n  = ge ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
        quo_n  = {quo[WIDTH-2:0], ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        done    = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL)                  state_n = MUL;
                    else if (op == OP_DIV && b != '0)  state_n = DIV;
                    else                               state_n = DONE;
                end
            end
            MUL:     if (last) state_n = DONE;
            DIV:     if (last) state_n = FIX;
            FIX:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result registers
    always_ff @(posedge clk) begin
        if (clr) begin
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            qm1         <= 1'b0;
            mcand       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        cnt         <= '0;
                        if (op == OP_MUL) begin
                            mcand  <= a;
                            acc_hi <= '0;
                            acc_lo <= b;
                            qm1    <= 1'b0;
                        end else if (op == OP_DIV) begin
                            if (b == '0) begin
                                result_lo   <= '1;
                                result_hi   <= a;
                                div_by_zero <= 1'b1;
                            end else begin
                                quo   <= a_mag;
                                rem   <= '0;
                                dvs   <= b_mag;
                                neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                                neg_r <= a[WIDTH-1];
                            end
                        end else begin
                            result_lo <= single;
                            result_hi <= '0;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= hi_n;
                    acc_lo <= lo_n;
                    qm1    <= acc_lo[0];
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result_hi <= hi_n[WIDTH-1:0];
                        result_lo <= lo_n;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    result_lo <= neg_q ? -quo : quo;
                    result_hi <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32).
// Stimulus pushes expected results computed with plain 64-bit arithmetic;
// a monitor pops and compares whenever done is seen.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
        int           acc;
        logic [3:0]   op;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model in plain arithmetic on 64-bit integers
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint lx, ly, p, q, r;
        int     amt;
        logic [W-1:0] t;
        lx    = $signed(x);
        ly    = $signed(y);
        amt   = int'(y % 32);
        e.lo  = '0;
        e.hi  = '0;
        e.dbz = 1'b0;
        e.lat = 1;
        e.acc = 0;
        e.op  = o;
        t     = x;
        case (o)
            4'h0: e.lo = x + y;
            4'h1: e.lo = x - y;
            4'h4: e.lo = x & y;
            4'h5: e.lo = x | y;
            4'h6: e.lo = x >> amt;
            4'h7: e.lo = $signed(x) >>> amt;
            4'h8: e.lo = x << amt;
            4'h9: begin
                for (int i = 0; i < amt; i++) t = {t[0], t[W-1:1]};
                e.lo = t;
            end
            4'hA: begin
                for (int i = 0; i < amt; i++) t = {t[W-2:0], t[W-1]};
                e.lo = t;
            end
            4'hB: e.lo = 0 - x;
            4'hC: e.lo = ~x;
            4'h3: begin
                p     = lx * ly;
                e.lo  = p[31:0];
                e.hi  = p[63:32];
                e.lat = W + 1;
            end
            4'h2: begin
                if (y == 0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else begin
                    q     = lx / ly;
                    r     = lx % ly;
                    e.lo  = q[31:0];
                    e.hi  = r[31:0];
                    e.lat = W + 2;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: actual=done required=no_done (t=%0t)", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("op%h_lo", mon_e.op), 64'(result_lo), 64'(mon_e.lo));
                chk($sformatf("op%h_hi", mon_e.op), 64'(result_hi), 64'(mon_e.hi));
                chk($sformatf("op%h_dbz", mon_e.op), 64'(div_by_zero), 64'(mon_e.dbz));
                chk($sformatf("op%h_latency", mon_e.op), 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    task automatic noise();
        start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        op    = 4'($urandom_range(0, 15));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy !== 1'b0 && guard < 200) begin
            noise();
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle_timeout: actual=busy required=idle within 200 cycles");
        end
        start = 1'b0;
    endtask

    // Issue one op; with early=1 start is raised in the DONE cycle of the previous op
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
        exp_t e;
        int   guard = 0;
        if (early) begin
            while (done !== 1'b1 && guard < 200) begin
                noise();
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wait_done_timeout: actual=no_done required=done within 200 cycles");
            end
        end else begin
            wait_idle();
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e     = model(o, x, y);
        e.acc = cyc + (early ? 2 : 1);
        sbq.push_back(e);
        if (early) @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom_range(0, 15));
        a     = $urandom;
        b     = $urandom;
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_lo", 64'(result_lo), 64'd0);
        chk("reset_hi", 64'(result_hi), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        clr = 1'b0;

        run_op(4'h3, 32'hFFFF_FFF9, 32'h0000_0006, 0);
        run_op(4'h3, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(4'h2, 32'hFFFF_FFEF, 32'h0000_0005, 0);
        run_op(4'h2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'h2, 32'h0000_0009, 32'h0000_0000, 0);
        run_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'h1, 32'h0000_0003, 32'h0000_0005, 0);
        run_op(4'h9, 32'h8000_0001, 32'h0000_0004, 0);
        run_op(4'h7, 32'h8000_0001, 32'h0000_0004, 0);
        run_op(4'h6, 32'h8000_0001, 32'h0000_0004, 0);
        run_op(4'hA, 32'h8000_0001, 32'h0000_0004, 0);
        run_op(4'h9, 32'h8000_0001, 32'h0000_0024, 0);
        run_op(4'hA, 32'h8000_0001, 32'h0000_0024, 0);
        run_op(4'h7, 32'h8000_0001, 32'h0000_0024, 0);
        run_op(4'h8, 32'h8000_0001, 32'h0000_0004, 0);
        run_op(4'h9, 32'h1234_5678, 32'h0000_0000, 0);
        run_op(4'hA, 32'h1234_5678, 32'hFFFF_FFE0, 0);
        run_op(4'hB, 32'h0000_0001, 32'h0000_0000, 0);
        run_op(4'hC, 32'h0F0F_00FF, 32'h0000_0000, 0);
        run_op(4'h4, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_op(4'h5, 32'hF0F0_1234, 32'h0FF0_0001, 0);
        run_op(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        // back-to-back: start already high in the DONE cycle
        run_op(4'h0, 32'h0000_0010, 32'h0000_0020, 0);
        run_op(4'h1, 32'h0000_0010, 32'h0000_0020, 1);
        run_op(4'h3, 32'h0000_1234, 32'hFFFF_0001, 1);
        run_op(4'h2, 32'h0000_0064, 32'hFFFF_FFF9, 1);

        // abort a MUL with clr; leave nonzero results beforehand
        run_op(4'h2, 32'h0000_0009, 32'h0000_0000, 0);
        wait_idle();
        start = 1'b1;
        op    = 4'h3;
        a     = $urandom;
        b     = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 4'h0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_lo", 64'(result_lo), 64'd0);
        chk("abort_hi", 64'(result_hi), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        repeat (40) @(negedge clk);
        run_op(4'h0, 32'h0000_0007, 32'h0000_0008, 0);

        for (int n = 0; n < 80; n++) begin
            run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), bit'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
